// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, flush, hold and a
// saturating count of inserted load-use bubbles.
module id_ex_register (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegDst,
    input  logic        Jump,
    input  logic        JumpRegister,
    input  logic        Link,
    input  logic        Branch,
    input  logic        MemRead,
    input  logic        MemToReg,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] PCPlus4_in,
    input  logic [31:0] ReadData1_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] SignExt_in,
    input  logic [4:0]  Rs_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [4:0]  Shamt_in,
    input  logic        Flush,
    input  logic        Hold,
    output logic        RegDst_EX,
    output logic        Jump_EX,
    output logic        JumpRegister_EX,
    output logic        Link_EX,
    output logic        Branch_EX,
    output logic        MemRead_EX,
    output logic        MemToReg_EX,
    output logic        MemWrite_EX,
    output logic        ALUSrc_EX,
    output logic        RegWrite_EX,
    output logic [3:0]  ALUOp_EX,
    output logic [31:0] PCPlus4_EX,
    output logic [31:0] ReadData1_EX,
    output logic [31:0] ReadData2_EX,
    output logic [31:0] SignExt_EX,
    output logic [4:0]  Rs_EX,
    output logic [4:0]  Rt_EX,
    output logic [4:0]  Rd_EX,
    output logic [4:0]  Shamt_EX,
    output logic        Stall,
    output logic [15:0] BubbleCount
);

    typedef struct packed {
        logic        reg_dst;
        logic        jump;
        logic        jump_register;
        logic        link;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [3:0]  alu_op;
        logic [31:0] pc_plus4;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] sign_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } stage_t;

    stage_t      stage_q;
    stage_t      stage_in;
    stage_t      bubble;
    logic [15:0] count_q;
    logic        lu;

    always_comb begin
        stage_in = '{
            reg_dst:       RegDst,
            jump:          Jump,
            jump_register: JumpRegister,
            link:          Link,
            branch:        Branch,
            mem_read:      MemRead,
            mem_to_reg:    MemToReg,
            mem_write:     MemWrite,
            alu_src:       ALUSrc,
            reg_write:     RegWrite,
            alu_op:        ALUOp,
            pc_plus4:      PCPlus4_in,
            read_data1:    ReadData1_in,
            read_data2:    ReadData2_in,
            sign_ext:      SignExt_in,
            rs:            Rs_in,
            rt:            Rt_in,
            rd:            Rd_in,
            shamt:         Shamt_in
        };
        // A bubble is a NOP whose ALU op is still a harmless add.
        bubble        = '0;
        bubble.alu_op = 4'b0010;
    end

    assign lu = stage_q.mem_read && (stage_q.rt != 5'd0) &&
                ((stage_q.rt == Rs_in) || (stage_q.rt == Rt_in));

    assign Stall = lu && !Flush && !Hold && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_q <= '0;
            count_q <= '0;
        end else if (Flush) begin
            stage_q <= bubble;
        end else if (Hold) begin
            stage_q <= stage_q;
        end else if (lu) begin
            stage_q <= bubble;
            if (count_q != '1)
                count_q <= count_q + 16'd1;
        end else begin
            stage_q <= stage_in;
        end
    end

    assign RegDst_EX       = stage_q.reg_dst;
    assign Jump_EX         = stage_q.jump;
    assign JumpRegister_EX = stage_q.jump_register;
    assign Link_EX         = stage_q.link;
    assign Branch_EX       = stage_q.branch;
    assign MemRead_EX      = stage_q.mem_read;
    assign MemToReg_EX     = stage_q.mem_to_reg;
    assign MemWrite_EX     = stage_q.mem_write;
    assign ALUSrc_EX       = stage_q.alu_src;
    assign RegWrite_EX     = stage_q.reg_write;
    assign ALUOp_EX        = stage_q.alu_op;
    assign PCPlus4_EX      = stage_q.pc_plus4;
    assign ReadData1_EX    = stage_q.read_data1;
    assign ReadData2_EX    = stage_q.read_data2;
    assign SignExt_EX      = stage_q.sign_ext;
    assign Rs_EX           = stage_q.rs;
    assign Rt_EX           = stage_q.rt;
    assign Rd_EX           = stage_q.rd;
    assign Shamt_EX        = stage_q.shamt;
    assign BubbleCount     = count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register: reset, load, load-use bubbles,
// $zero exemption, flush/hold priority, hold retention and count saturation.
module tb_id_ex_register;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        RegDst, Jump, JumpRegister, Link, Branch;
    logic        MemRead, MemToReg, MemWrite, ALUSrc, RegWrite;
    logic [3:0]  ALUOp;
    logic [31:0] PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in;
    logic [4:0]  Rs_in, Rt_in, Rd_in, Shamt_in;
    logic        Flush, Hold;
    logic        RegDst_EX, Jump_EX, JumpRegister_EX, Link_EX, Branch_EX;
    logic        MemRead_EX, MemToReg_EX, MemWrite_EX, ALUSrc_EX, RegWrite_EX;
    logic [3:0]  ALUOp_EX;
    logic [31:0] PCPlus4_EX, ReadData1_EX, ReadData2_EX, SignExt_EX;
    logic [4:0]  Rs_EX, Rt_EX, Rd_EX, Shamt_EX;
    logic        Stall;
    logic [15:0] BubbleCount;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    id_ex_register dut (
        .Clk(Clk), .Reset(Reset),
        .RegDst(RegDst), .Jump(Jump), .JumpRegister(JumpRegister), .Link(Link),
        .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .PCPlus4_in(PCPlus4_in), .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
        .SignExt_in(SignExt_in), .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
        .Shamt_in(Shamt_in), .Flush(Flush), .Hold(Hold),
        .RegDst_EX(RegDst_EX), .Jump_EX(Jump_EX), .JumpRegister_EX(JumpRegister_EX),
        .Link_EX(Link_EX), .Branch_EX(Branch_EX), .MemRead_EX(MemRead_EX),
        .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX), .ALUSrc_EX(ALUSrc_EX),
        .RegWrite_EX(RegWrite_EX), .ALUOp_EX(ALUOp_EX), .PCPlus4_EX(PCPlus4_EX),
        .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX), .SignExt_EX(SignExt_EX),
        .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX), .Shamt_EX(Shamt_EX),
        .Stall(Stall), .BubbleCount(BubbleCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Active edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        {RegDst, Jump, JumpRegister, Link, Branch} = '0;
        {MemRead, MemToReg, MemWrite, ALUSrc, RegWrite} = '0;
        ALUOp = 4'b0000;
        PCPlus4_in = '0; ReadData1_in = '0; ReadData2_in = '0; SignExt_in = '0;
        Rs_in = '0; Rt_in = '0; Rd_in = '0; Shamt_in = '0;
        Flush = 1'b0; Hold = 1'b0;
    endtask

    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_inputs();
        MemRead = 1'b1; MemToReg = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1;
        ALUOp = 4'b0010; Rs_in = rs; Rt_in = rt; SignExt_in = 32'h4;
    endtask

    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_inputs();
        RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 4'b0010;
        Rs_in = rs; Rt_in = rt; Rd_in = rd;
    endtask

    initial begin
        // Reset for two edges with a live instruction on the inputs
        Reset = 1'b1;
        drive_lw(5'd1, 5'd8);
        PCPlus4_in = 32'h100;
        tick();
        tick();
        check("rst_stall", Stall, 1'b0);
        check("rst_memread", MemRead_EX, 1'b0);
        check("rst_regwrite", RegWrite_EX, 1'b0);
        check("rst_aluop", ALUOp_EX, 4'b0000);
        check("rst_pc", PCPlus4_EX, 32'h0);
        check("rst_rt", Rt_EX, 5'd0);
        check("rst_count", BubbleCount, 16'h0);

        // Plain load of an add
        Reset = 1'b0;
        clear_inputs();
        RegWrite = 1'b1; ALUOp = 4'b0010; Rd_in = 5'd5; ReadData1_in = 32'h10;
        PCPlus4_in = 32'h104; Shamt_in = 5'd3;
        check("add_stall", Stall, 1'b0);
        tick();
        check("add_regwrite", RegWrite_EX, 1'b1);
        check("add_rd", Rd_EX, 5'd5);
        check("add_rd1", ReadData1_EX, 32'h10);
        check("add_aluop", ALUOp_EX, 4'b0010);
        check("add_pc", PCPlus4_EX, 32'h104);
        check("add_shamt", Shamt_EX, 5'd3);

        // Load-use: lw $8 then consumer of $8 via Rs
        drive_lw(5'd2, 5'd8);
        tick();
        check("lw_memread", MemRead_EX, 1'b1);
        check("lw_rt", Rt_EX, 5'd8);
        drive_add(5'd8, 5'd9, 5'd10);
        #1;
        check("lu_stall", Stall, 1'b1);
        tick();
        check("lu_bub_regwrite", RegWrite_EX, 1'b0);
        check("lu_bub_memread", MemRead_EX, 1'b0);
        check("lu_bub_memtoreg", MemToReg_EX, 1'b0);
        check("lu_bub_regdst", RegDst_EX, 1'b0);
        check("lu_bub_aluop", ALUOp_EX, 4'b0010);
        check("lu_bub_rs", Rs_EX, 5'd0);
        check("lu_bub_rt", Rt_EX, 5'd0);
        check("lu_count", BubbleCount, 16'd1);
        check("lu_stall_clear", Stall, 1'b0);
        tick();
        check("lu_reload_rs", Rs_EX, 5'd8);
        check("lu_reload_rd", Rd_EX, 5'd10);
        check("lu_reload_regwrite", RegWrite_EX, 1'b1);
        check("lu_reload_count", BubbleCount, 16'd1);

        // Load-use through Rt match
        drive_lw(5'd2, 5'd12);
        tick();
        drive_add(5'd3, 5'd12, 5'd13);
        #1;
        check("lu_rt_stall", Stall, 1'b1);
        tick();
        check("lu_rt_count", BubbleCount, 16'd2);
        tick();
        check("lu_rt_reload", Rd_EX, 5'd13);

        // $zero exemption
        drive_lw(5'd2, 5'd0);
        tick();
        check("z_memread", MemRead_EX, 1'b1);
        drive_add(5'd0, 5'd0, 5'd11);
        #1;
        check("z_stall", Stall, 1'b0);
        tick();
        check("z_rd", Rd_EX, 5'd11);
        check("z_memread2", MemRead_EX, 1'b0);
        check("z_count", BubbleCount, 16'd2);

        // Flush wins over Hold and load-use
        drive_lw(5'd2, 5'd8);
        tick();
        drive_add(5'd8, 5'd1, 5'd4);
        Flush = 1'b1; Hold = 1'b1;
        #1;
        check("fl_stall", Stall, 1'b0);
        tick();
        check("fl_memread", MemRead_EX, 1'b0);
        check("fl_regwrite", RegWrite_EX, 1'b0);
        check("fl_aluop", ALUOp_EX, 4'b0010);
        check("fl_rs", Rs_EX, 5'd0);
        check("fl_count", BubbleCount, 16'd2);

        // Hold keeps a sw frozen for three edges while inputs change
        clear_inputs();
        MemWrite = 1'b1; ALUSrc = 1'b1; ALUOp = 4'b0000;
        Rs_in = 5'd4; Rt_in = 5'd6; SignExt_in = 32'h20; ReadData2_in = 32'hCAFE;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_add(5'(i + 1), 5'(i + 2), 5'(i + 3));
            ReadData2_in = 32'(i);
            Hold = 1'b1;
            #1;
            check("hold_stall", Stall, 1'b0);
            tick();
            check("hold_memwrite", MemWrite_EX, 1'b1);
            check("hold_regwrite", RegWrite_EX, 1'b0);
            check("hold_aluop", ALUOp_EX, 4'b0000);
            check("hold_rt", Rt_EX, 5'd6);
            check("hold_signext", SignExt_EX, 32'h20);
            check("hold_rd2", ReadData2_EX, 32'hCAFE);
            check("hold_count", BubbleCount, 16'd2);
        end
        Hold = 1'b0;

        // Saturation: preset the counter to FFFE, then three load-use pairs
        @(negedge Clk);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        for (int i = 0; i < 3; i++) begin
            drive_lw(5'd2, 5'd7);
            tick();
            drive_add(5'd7, 5'd3, 5'd9);
            #1;
            check("sat_stall", Stall, 1'b1);
            tick();
            check("sat_count", BubbleCount, 16'hFFFF);
        end

        // Reset in the middle of a stall
        drive_lw(5'd2, 5'd7);
        tick();
        drive_add(5'd7, 5'd3, 5'd9);
        Reset = 1'b1;
        #1;
        check("mid_rst_stall", Stall, 1'b0);
        tick();
        check("mid_rst_count", BubbleCount, 16'h0);
        check("mid_rst_memread", MemRead_EX, 1'b0);
        check("mid_rst_aluop", ALUOp_EX, 4'b0000);
        Reset = 1'b0;
        tick();
        check("post_rst_rd", Rd_EX, 5'd9);
        check("post_rst_count", BubbleCount, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 The block SHALL use one clock, Clk; reset SHALL be Reset, synchronous and active-high.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  synchronous active-high reset.
REQ-004 RegDst, Jump, JumpRegister, Link, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite  in  1 each  decode control from the ID-stage controller.
REQ-005 ALUOp  in  4  ALU operation code from the controller.
REQ-006 PCPlus4_in, ReadData1_in, ReadData2_in, SignExt_in  in  32 each  ID-stage datapath values.
REQ-007 Rs_in, Rt_in, Rd_in, Shamt_in  in  5 each  ID-stage instruction fields.
REQ-008 Flush  in  1  EX-resolved branch/jump taken; cancels the ID instruction.
REQ-009 Hold  in  1  freeze the EX stage (multi-cycle op).
REQ-010 Each control, ALUOp, datapath and field input SHALL have a registered output of equal width, named with suffix _EX (for example RegWrite_EX, ALUOp_EX, Rt_EX).
REQ-011 Stall  out  1  combinational; freezes PC and IF/ID.
REQ-012 BubbleCount  out  16  saturating count of load-use bubbles inserted.

Function
REQ-013 Load-use hazard (LU) SHALL be the combinational term MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_in) | (Rt_EX == Rt_in)).
REQ-014 Stall SHALL equal LU & ~Flush & ~Hold & ~Reset.
REQ-015 The per-edge action SHALL follow the first matching rule in this order: Reset, Flush, Hold, LU, load.
REQ-016 Reset action SHALL clear all _EX outputs and BubbleCount to 0.
REQ-017 Flush action SHALL write a bubble and SHALL NOT increment BubbleCount.
REQ-018 A bubble SHALL set the ten 1-bit controls to 0, ALUOp_EX to 4'b0010 and all data and field outputs to 0.
REQ-019 Hold action SHALL retain every _EX output and BubbleCount unchanged.
REQ-020 LU action SHALL write a bubble and increment BubbleCount by 1, saturating at 16'hFFFF.
REQ-021 Load action SHALL capture all inputs into the matching _EX outputs.
REQ-022 Latency SHALL be one cycle: inputs present before edge N appear on _EX outputs after edge N.
REQ-023 A stalled instruction SHALL be held upstream, then re-presented and loaded on the next edge, because the bubble clears MemRead_EX and so clears LU.
REQ-024 Rt_EX = 0 SHALL never raise LU, even when MemRead_EX = 1.
REQ-025 Stall SHALL assert for exactly one cycle per load-use pair; back-to-back loads SHALL be handled as independent pairs.
REQ-026 Flush and LU in the same cycle SHALL produce one bubble, Stall = 0, and no count increment.
REQ-027 Hold and Flush in the same cycle SHALL act as Flush.
REQ-028 The block SHALL contain no other state; outputs SHALL be glitch-free registers, except Stall.

Reset
REQ-029 Reset SHALL take effect on the first rising Clk edge while it is high, including mid-stall or mid-hold; there SHALL be no asynchronous path.
REQ-030 While Reset is high, Stall SHALL be 0.
REQ-031 On the first edge after Reset falls, the normal priority rules SHALL apply.

Verification
REQ-032 Reset then load: Reset=1 for 2 edges, then drive add (RegWrite=1, ALUOp=0010, Rd_in=5, ReadData1_in=32'h10) -> all zero during reset; one edge later RegWrite_EX=1, Rd_EX=5, ReadData1_EX=32'h10.
REQ-033 Load-use: load lw (MemRead=1, Rt_in=8), next drive Rs_in=8 -> Stall=1 that cycle; after the edge all controls_EX=0 and BubbleCount=1; the re-presented instruction loads on the next edge with Stall=0.
REQ-034 $zero exemption: lw with Rt_in=0 followed by Rs_in=0 -> Stall=0, no bubble, BubbleCount unchanged.
REQ-035 Flush priority: Flush=1 with LU true and Hold=1 -> Stall=0, bubble written, BubbleCount unchanged.
REQ-036 Hold: load a sw, then Hold=1 for 3 edges while inputs change -> MemWrite_EX=1 and all other _EX outputs unchanged throughout.
REQ-037 Saturation: preload BubbleCount to 16'hFFFE, create 3 load-use pairs -> BubbleCount reads FFFF, FFFF, FFFF; a mid-sequence Reset returns it to 0.
